// File: rtl/mem_line_bridge.sv
// mem_line_bridge: serializes one 512-bit cache-line request from the L2 onto a
// 64-bit command/data bus and deserializes load beats back into a line.
// Only one request is in flight at a time. Every output is a register or a
// decode of the state register, so no bus input reaches a bus output through
// combinational logic.
//
// Handshake rules: a valid is held, with a stable payload, until the cycle in
// which its ready is sampled high. Read beats (bus_rdata_valid) carry no
// backpressure. bus_wack is a single-cycle pulse. mem_req_valid is sampled
// only while idle, and mem_rsp_valid is a one-cycle completion pulse.
module mem_line_bridge #(
    parameter int          ADDR_W   = 32,
    parameter logic [3:0]  OP_LOAD  = 4'd4,
    parameter logic [3:0]  OP_STORE = 4'd7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_req_valid,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [511:0]      mem_req_store_data,
    input  logic [3:0]        mem_req_opcode,
    output logic              mem_rsp_valid,
    output logic [511:0]      mem_rsp_load_data,
    output logic              bus_cmd_valid,
    input  logic              bus_cmd_ready,
    output logic              bus_cmd_write,
    output logic [ADDR_W-1:0] bus_cmd_addr,
    output logic              bus_wdata_valid,
    input  logic              bus_wdata_ready,
    output logic [63:0]       bus_wdata,
    output logic              bus_wlast,
    input  logic              bus_wack,
    input  logic              bus_rdata_valid,
    input  logic [63:0]       bus_rdata,
    input  logic              bus_rlast,
    output logic              busy,
    output logic              bad_op,
    output logic              protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_WDATA = 3'd2,
        S_WACK  = 3'd3,
        S_RDATA = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t       state;
    logic [511:0] req_line;
    logic [2:0]   beat;
    logic [2:0]   beat_nxt;

    // The low six address bits select a byte within the line; the bus only
    // ever sees line-aligned addresses.
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b0};

    assign beat_nxt = beat + 3'd1;

    // Busy is a pure decode of the state register.
    assign busy = (state != S_IDLE);

    // Main transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            req_line          <= '0;
            beat              <= '0;
            mem_rsp_valid     <= 1'b0;
            mem_rsp_load_data <= '0;
            bus_cmd_valid     <= 1'b0;
            bus_cmd_write     <= 1'b0;
            bus_cmd_addr      <= '0;
            bus_wdata_valid   <= 1'b0;
            bus_wdata         <= '0;
            bus_wlast         <= 1'b0;
            bad_op            <= 1'b0;
            protocol_err      <= 1'b0;
        end else begin
            // Bus events that arrive in the wrong phase are dropped but recorded.
            if (bus_rdata_valid && (state != S_RDATA)) protocol_err <= 1'b1;
            if (bus_wack && (state != S_WACK))         protocol_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        req_line      <= mem_req_store_data;
                        bus_cmd_addr  <= mem_req_addr & LINE_MASK;
                        bus_cmd_write <= (mem_req_opcode == OP_STORE);
                        if ((mem_req_opcode == OP_LOAD) || (mem_req_opcode == OP_STORE)) begin
                            bus_cmd_valid <= 1'b1;
                            state         <= S_CMD;
                        end else begin
                            // Unsupported opcode: complete at once, load data untouched.
                            bad_op        <= 1'b1;
                            mem_rsp_valid <= 1'b1;
                            state         <= S_RESP;
                        end
                    end
                end

                S_CMD: begin
                    if (bus_cmd_ready) begin
                        bus_cmd_valid <= 1'b0;
                        beat          <= 3'd0;
                        if (bus_cmd_write) begin
                            bus_wdata_valid <= 1'b1;
                            bus_wdata       <= req_line[63:0];
                            bus_wlast       <= 1'b0;
                            state           <= S_WDATA;
                        end else begin
                            state <= S_RDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (bus_wdata_ready) begin
                        if (beat == 3'd7) begin
                            bus_wdata_valid <= 1'b0;
                            bus_wlast       <= 1'b0;
                            state           <= S_WACK;
                        end else begin
                            // Preload the next beat so the payload is a register.
                            beat      <= beat_nxt;
                            bus_wdata <= req_line[{beat_nxt, 6'b0} +: 64];
                            bus_wlast <= (beat_nxt == 3'd7);
                        end
                    end
                end

                S_WACK: begin
                    if (bus_wack) begin
                        mem_rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end
                end

                S_RDATA: begin
                    if (bus_rdata_valid) begin
                        mem_rsp_load_data[{beat, 6'b0} +: 64] <= bus_rdata;
                        // The local beat count decides the end; rlast is only checked.
                        if (bus_rlast != (beat == 3'd7)) protocol_err <= 1'b1;
                        beat <= beat_nxt;
                        if (beat == 3'd7) begin
                            mem_rsp_valid <= 1'b1;
                            state         <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    mem_rsp_valid <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_bridge.sv
// tb_mem_line_bridge: directed and randomized line loads/stores against a
// transaction-level reference model of the bridge.
module tb_mem_line_bridge;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_req_store_data;
    logic [3:0]   mem_req_opcode;
    logic         mem_rsp_valid;
    logic [511:0] mem_rsp_load_data;
    logic         bus_cmd_valid;
    logic         bus_cmd_ready;
    logic         bus_cmd_write;
    logic [31:0]  bus_cmd_addr;
    logic         bus_wdata_valid;
    logic         bus_wdata_ready;
    logic [63:0]  bus_wdata;
    logic         bus_wlast;
    logic         bus_wack;
    logic         bus_rdata_valid;
    logic [63:0]  bus_rdata;
    logic         bus_rlast;
    logic         busy;
    logic         bad_op;
    logic         protocol_err;

    mem_line_bridge #(
        .ADDR_W   (32),
        .OP_LOAD  (4'd4),
        .OP_STORE (4'd7)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_store_data (mem_req_store_data),
        .mem_req_opcode     (mem_req_opcode),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_load_data  (mem_rsp_load_data),
        .bus_cmd_valid      (bus_cmd_valid),
        .bus_cmd_ready      (bus_cmd_ready),
        .bus_cmd_write      (bus_cmd_write),
        .bus_cmd_addr       (bus_cmd_addr),
        .bus_wdata_valid    (bus_wdata_valid),
        .bus_wdata_ready    (bus_wdata_ready),
        .bus_wdata          (bus_wdata),
        .bus_wlast          (bus_wlast),
        .bus_wack           (bus_wack),
        .bus_rdata_valid    (bus_rdata_valid),
        .bus_rdata          (bus_rdata),
        .bus_rlast          (bus_rlast),
        .busy               (busy),
        .bad_op             (bad_op),
        .protocol_err       (protocol_err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    logic [511:0] mdl_load;      // line the bridge should currently present
    bit           mdl_bad;       // sticky bad-op flag
    bit           mdl_perr;      // sticky protocol-error flag
    logic [63:0]  exp_q[$];      // write beats still expected on the bus

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        mem_req_valid      = 1'b0;
        mem_req_addr       = '0;
        mem_req_store_data = '0;
        mem_req_opcode     = '0;
        bus_cmd_ready      = 1'b0;
        bus_wdata_ready    = 1'b0;
        bus_wack           = 1'b0;
        bus_rdata_valid    = 1'b0;
        bus_rdata          = '0;
        bus_rlast          = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_cmd_valid"},   bus_cmd_valid, 0);
        check_val({tag, "_wdata_valid"}, bus_wdata_valid, 0);
        check_val({tag, "_wlast"},       bus_wlast, 0);
        check_val({tag, "_rsp_valid"},   mem_rsp_valid, 0);
        check_val({tag, "_busy"},        busy, 0);
        check_val({tag, "_bad_op"},      bad_op, 0);
        check_val({tag, "_perr"},        protocol_err, 0);
        check_val({tag, "_load_data"},   mem_rsp_load_data, 0);
        check_val({tag, "_cmd_addr"},    bus_cmd_addr, 0);
        check_val({tag, "_wdata"},       bus_wdata, 0);
    endtask

    task automatic clear_model();
        mdl_load = '0;
        mdl_bad  = 1'b0;
        mdl_perr = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        clear_model();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Drop the request after the completion pulse and confirm the pulse is one cycle.
    task automatic finish_rsp();
        mem_req_valid = 1'b0;
        tick();
        check_val("rsp_pulse_width", mem_rsp_valid, 0);
        check_val("busy_after_rsp", busy, 0);
    endtask

    // One L2 request. mode: 0 no stalls, 1 wready toggles, 2 random stalls/gaps.
    // rlast_bad_at marks rlast on that extra beat; reset_at resets after that many read beats.
    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [511:0] line,
                          input int cmd_stall, input int mode, input int wack_dly,
                          input int rlast_bad_at, input int reset_at);
        logic [31:0]  exp_addr;
        logic [511:0] rline;
        logic [63:0]  w;
        logic [3:0]   kn;
        bit           is_load, is_store, rdy, tog;
        int           t0, k, stall;

        exp_addr = {addr[31:6], 6'b0};
        is_load  = (op == 4'd4);
        is_store = (op == 4'd7);
        exp_q.delete();
        if (is_store) for (int i = 0; i < 8; i++) exp_q.push_back(line[i*64 +: 64]);

        mem_req_valid      = 1'b1;
        mem_req_addr       = addr;
        mem_req_store_data = line;
        mem_req_opcode     = op;
        tick();
        t0 = cyc;
        // Fields change under a held request; the bridge must ignore them.
        mem_req_addr       = $urandom;
        mem_req_store_data = rand_line();
        mem_req_opcode     = 4'($urandom_range(0, 15));

        if (!is_load && !is_store) begin
            mdl_bad = 1'b1;
            check_val("badop_rsp_c1", mem_rsp_valid, 1);
            check_val("badop_no_cmd", bus_cmd_valid, 0);
            check_val("badop_no_wdata", bus_wdata_valid, 0);
            check_val("badop_flag", bad_op, 1);
            check_val("badop_load_kept", mem_rsp_load_data, mdl_load);
            finish_rsp();
            check_val("badop_sticky", bad_op, 1);
            return;
        end

        check_val("cmd_valid_c1", bus_cmd_valid, 1);
        stall = cmd_stall;
        for (int c = 0; c < 100; c++) begin
            check_val("cmd_valid_hold", bus_cmd_valid, 1);
            check_val("cmd_addr", bus_cmd_addr, exp_addr);
            check_val("cmd_write", bus_cmd_write, is_store);
            check_val("no_wdata_in_cmd", bus_wdata_valid, 0);
            check_val("no_rsp_in_cmd", mem_rsp_valid, 0);
            check_val("busy_cmd", busy, 1);
            rdy = (stall == 0);
            bus_cmd_ready = rdy;
            tick();
            if (rdy) break;
            stall--;
        end
        bus_cmd_ready = 1'b0;
        check_val("cmd_valid_drop", bus_cmd_valid, 0);

        if (is_store) begin
            k   = 0;
            tog = 1'b1;
            for (int c = 0; c < 200 && k < 8; c++) begin
                check_val("wdata_valid", bus_wdata_valid, 1);
                check_val("wdata", bus_wdata, exp_q[0]);
                check_val("wlast", bus_wlast, (k == 7));
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
                tog = ~tog;
                bus_wdata_ready = rdy;
                tick();
                if (rdy) begin
                    void'(exp_q.pop_front());
                    k++;
                end
            end
            bus_wdata_ready = 1'b0;
            check_val("wbeat_count", k, 8);
            check_val("wdata_valid_drop", bus_wdata_valid, 0);
            check_val("wlast_drop", bus_wlast, 0);
            for (int d = 0; d < wack_dly; d++) begin
                check_val("no_rsp_before_wack", mem_rsp_valid, 0);
                check_val("busy_wack", busy, 1);
                tick();
            end
            bus_wack = 1'b1;
            tick();
            bus_wack = 1'b0;
        end else begin
            k     = 0;
            rline = mdl_load;
            for (int c = 0; c < 200 && k < 8; c++) begin
                check_val("no_rsp_early", mem_rsp_valid, 0);
                check_val("no_wdata_in_load", bus_wdata_valid, 0);
                if (mode == 2 && $urandom_range(0, 2) == 0) begin
                    tick();
                    continue;
                end
                kn = 4'(k);
                w  = (mode == 0) ? {16{kn}} : {$urandom, $urandom};
                rline[k*64 +: 64] = w;
                bus_rdata_valid = 1'b1;
                bus_rdata       = w;
                bus_rlast       = (k == 7) || (k == rlast_bad_at);
                if (k == rlast_bad_at && k != 7) mdl_perr = 1'b1;
                tick();
                k++;
                bus_rdata_valid = 1'b0;
                bus_rlast       = 1'b0;
                bus_rdata       = '0;
                if (k == reset_at) begin
                    reset_n = 1'b0;
                    #1;
                    check_reset_values("midreset");
                    clear_model();
                    mem_req_valid = 1'b0;
                    for (int d = 0; d < 3; d++) begin
                        tick();
                        check_val("midreset_no_rsp", mem_rsp_valid, 0);
                        check_val("midreset_no_cmd", bus_cmd_valid, 0);
                    end
                    reset_n = 1'b1;
                    tick();
                    return;
                end
            end
            check_val("rbeat_count", k, 8);
            mdl_load = rline;
        end

        check_val("rsp_valid", mem_rsp_valid, 1);
        if (mode == 0 && cmd_stall == 0)
            check_val("rsp_cycle", cyc - t0 + 1, is_store ? 11 + wack_dly : 10);
        check_val("rsp_load_data", mem_rsp_load_data, mdl_load);
        check_val("perr_flag", protocol_err, mdl_perr);
        check_val("badop_flag_txn", bad_op, mdl_bad);
        finish_rsp();
    endtask

    // Stray bus events while idle must be ignored and flagged.
    task automatic stray_event(input bit is_wack);
        if (is_wack) bus_wack = 1'b1;
        else begin
            bus_rdata_valid = 1'b1;
            bus_rdata       = {$urandom, $urandom};
        end
        tick();
        bus_wack        = 1'b0;
        bus_rdata_valid = 1'b0;
        mdl_perr        = 1'b1;
        check_val("stray_perr", protocol_err, 1);
        check_val("stray_busy", busy, 0);
        check_val("stray_no_rsp", mem_rsp_valid, 0);
        check_val("stray_load_kept", mem_rsp_load_data, mdl_load);
    endtask

    task automatic random_txns(input int n);
        logic [3:0] op;
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) op = 4'd4;
            else if (r < 8) op = 4'd7;
            else begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd4 || op == 4'd7) op = 4'd9;
            end
            do_txn(op, $urandom, rand_line(), $urandom_range(0, 3), 2, $urandom_range(0, 4), -1, -1);
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] sline;
        for (int i = 0; i < 8; i++) sline[i*64 +: 64] = 64'(8'hA0 + i);

        do_reset();

        // Load with no stalls, pattern beats.
        do_txn(4'd4, 32'h1234_5678, '0, 0, 0, 0, -1, -1);
        // Store, no stalls, earliest wack.
        do_txn(4'd7, 32'h0000_1000, rand_line(), 0, 0, 0, -1, -1);
        // Store with toggling wready and wack 3 cycles after the last beat.
        do_txn(4'd7, 32'h8000_00FF, sline, 0, 1, 3, -1, -1);
        // Command stalled for 5 cycles, load then store.
        do_txn(4'd4, 32'hDEAD_BEEF, '0, 5, 0, 0, -1, -1);
        do_txn(4'd7, 32'h0BAD_F00D, rand_line(), 5, 2, 1, -1, -1);
        // Randomized traffic before any protocol error.
        random_txns(10);
        // Unsupported opcode.
        do_txn(4'd2, 32'h4444_4444, rand_line(), 0, 0, 0, -1, -1);
        // Protocol errors: early rlast on beat 3, then stray events while idle.
        do_txn(4'd4, 32'h5555_5540, '0, 0, 0, 0, 3, -1);
        stray_event(1'b1);
        stray_event(1'b0);
        // Reset in the middle of a load after beat 4, then a clean load.
        do_txn(4'd4, 32'h6666_6666, '0, 0, 0, 0, -1, 5);
        do_txn(4'd4, 32'h7777_7777, '0, 0, 0, 0, -1, -1);
        random_txns(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got still_running expected finished");
        $fatal(1, "time limit reached");
    end

endmodule
